cache_line_store: RTL and testbench
===================================

Name: cache_line_store

Overview:
- Direct-indexed cache storage array of 64 lines, used by the CPU block as its local cache.
- Each line holds a 64-bit data word, a MESI state and the stored Taddress tag.
- One synchronous write port and one registered read port share the single `addr` input. The CPU sweeps this port to search lines and to fill lines after a memory read.

Parameters:
- NUM_LINES, 64, number of cache lines; the index is `addr.Address_code[5:0]`.
- DATA_W, 64, width of the data word per line.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- we  input  1  write enable, sampled on the rising edge of clk.
- addr  input  Taddress (16)  line select for read and write; `Address_code` indexes the line.
- wdata  input  DATA_W  data to store on a write.
- mesi_state_in  input  Tmesi_state (2)  MESI state to store on a write.
- rdata  output  DATA_W  registered data of the line selected by `addr`.
- cache_mesi_state  output  Tmesi_state (2)  registered MESI state of the selected line.
- cache_addr  output  Taddress (16)  registered stored tag of the selected line.

Behaviour:
- Reset (reset=0, asynchronous):
  - All lines become data=0, tag=0, state=INV.
  - Outputs become rdata=0, cache_mesi_state=INV, cache_addr=0.
  - Reset held low overrides `we`.
  - Reset asserted mid-operation discards any pending write.
- Write: on a rising edge with reset=1, we=1 and `Address_code < NUM_LINES`, line[`Address_code`] takes:
  - data=wdata
  - state=mesi_state_in
  - tag=addr (full Taddress, `Page_reference` included)
- Read: on every rising edge with reset=1, the outputs load the contents of line[`Address_code`].
  - Read latency is 1 cycle: the value presented at edge N appears after edge N.
  - Outputs hold their value between edges.
- Read during write to the same line (write-first): the outputs after that edge show the newly written data, state and tag.
- Out-of-range index (`Address_code >= NUM_LINES`, e.g. 64 at the end of a sweep):
  - The write is ignored and no line changes.
  - The read returns rdata=0, cache_mesi_state=INV, cache_addr=0.
- `Page_reference` does not affect indexing. It is stored as part of the tag only.
- No internal state machine; storage array plus output registers only.
- There is no replacement policy or hit/miss logic; the CPU performs the tag compare.

Decomposition:
- definesPkg (shared) holds:
  - Taddress, a packed struct: `Page_reference[7:0]`, `Address_code[7:0]`.
  - Tmesi_state, a 2-bit enum: INV=2'b00, SHR=2'b01, EXC=2'b10, MOD=2'b11.
- No sub-module needed. An optional line-record struct (data, state, tag) may be declared locally.

Test Plan:
- Reset check: assert reset=0 asynchronously mid-cycle. Required: outputs go to 0/INV/0 immediately. Then sweep `Address_code` 0..63 with reset=1; every line reads cache_mesi_state=INV, rdata=0, cache_addr=0 with 1-cycle latency.
- Write/read line 5: write addr={0x00,0x05}, wdata=0xDEADBEEF_CAFEF00D, mesi_state_in=EXC, then drop we. Required: reading addr 5 gives rdata=0xDEADBEEF_CAFEF00D, EXC, cache_addr={0x00,0x05} one edge later. Lines 4 and 6 remain INV.
- Write-first collision: hold addr=7 with we=1, wdata=0x1111, MOD. Required: the outputs after that same edge already show 0x1111/MOD.
- Overwrite and tag: write line 63 with tag {0xAB,0x3F}, SHR, then overwrite with 0x2222, INV. Required: the reads return SHR/{0xAB,0x3F}, then INV/0x2222.
- Out of range: write with `Address_code`=64, 0x3333. Required: no line changes (line 0 unchanged), and the read of 64 returns 0/INV/0.
- Reset mid-operation: fill lines 0-3, pulse reset low during a write cycle. Required: all lines return to INV/0 and the in-flight write is lost.

Source files
------------

// File: rtl/definesPkg.sv
// Shared address and coherence-state types used by the CPU block and its cache storage.
package definesPkg;

  typedef struct packed {
    logic [7:0] Page_reference;
    logic [7:0] Address_code;
  } Taddress;

  typedef enum logic [1:0] {
    INV = 2'b00,
    SHR = 2'b01,
    EXC = 2'b10,
    MOD = 2'b11
  } Tmesi_state;

endpackage

// File: rtl/cache_line_store.sv
// Direct-indexed cache line storage: one synchronous write port and one registered,
// write-first read port sharing a single address.
module cache_line_store
  import definesPkg::*;
#(
  parameter int NUM_LINES = 64,
  parameter int DATA_W    = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  Taddress           addr,
  input  logic [DATA_W-1:0] wdata,
  input  Tmesi_state        mesi_state_in,
  output logic [DATA_W-1:0] rdata,
  output Tmesi_state        cache_mesi_state,
  output Taddress           cache_addr
);

  localparam int IDX_W = $clog2(NUM_LINES);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    Tmesi_state        state;
    Taddress           tag;
  } line_t;

  line_t            mem_r [NUM_LINES];
  logic             in_range_s;
  logic [IDX_W-1:0] idx_s;
  line_t            wr_line_s;

  // Decode the line index and build the record a write would store.
  always_comb begin
    in_range_s     = 32'(addr.Address_code) < NUM_LINES;
    idx_s          = addr.Address_code[IDX_W-1:0];
    wr_line_s      = '0;
    wr_line_s.data = wdata;
    wr_line_s.state = mesi_state_in;
    wr_line_s.tag  = addr;
  end

  // Storage array update and registered read; a same-edge write is forwarded to the outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_LINES; i++) begin
        mem_r[i] <= '0;
      end
      rdata            <= '0;
      cache_mesi_state <= INV;
      cache_addr       <= '0;
    end else begin
      if (we && in_range_s) begin
        mem_r[idx_s] <= wr_line_s;
      end
      // Indices past the array (e.g. the end of a sweep) read as an empty line.
      if (!in_range_s) begin
        rdata            <= '0;
        cache_mesi_state <= INV;
        cache_addr       <= '0;
      end else if (we) begin
        rdata            <= wr_line_s.data;
        cache_mesi_state <= wr_line_s.state;
        cache_addr       <= wr_line_s.tag;
      end else begin
        rdata            <= mem_r[idx_s].data;
        cache_mesi_state <= mem_r[idx_s].state;
        cache_addr       <= mem_r[idx_s].tag;
      end
    end
  end

endmodule

// File: tb/tb_cache_line_store.sv
// Directed bench for cache_line_store: reset, sweep, write/read, write-first,
// overwrite, out-of-range and mid-operation reset.
module tb_cache_line_store;
  import definesPkg::*;

  localparam int DATA_W = 64;

  logic              clk;
  logic              reset;
  logic              we;
  Taddress           addr;
  logic [DATA_W-1:0] wdata;
  Tmesi_state        mesi_state_in;
  logic [DATA_W-1:0] rdata;
  Tmesi_state        cache_mesi_state;
  Taddress           cache_addr;

  int vectors;
  int miscompares;

  cache_line_store #(.NUM_LINES(64), .DATA_W(DATA_W)) dut (
    .clk              (clk),
    .reset            (reset),
    .we               (we),
    .addr             (addr),
    .wdata            (wdata),
    .mesi_state_in    (mesi_state_in),
    .rdata            (rdata),
    .cache_mesi_state (cache_mesi_state),
    .cache_addr       (cache_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] ed, input Tmesi_state es,
                     input logic [15:0] et);
    logic [81:0] obs;
    logic [81:0] exp;
    obs = {rdata, cache_mesi_state, cache_addr};
    exp = {ed, es, et};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed data=%h state=%b tag=%h, expected data=%h state=%b tag=%h",
             tag, obs[81:18], obs[17:16], obs[15:0], exp[81:18], exp[17:16], exp[15:0]);
    end
  endtask

  // One rising edge, then settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [63:0] d, input Tmesi_state s);
    addr = a; wdata = d; mesi_state_in = s; we = 1'b1;
    step();
    we = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a);
    addr = a; we = 1'b0;
    step();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1; we = 1'b0; addr = 16'h0000; wdata = 64'h0; mesi_state_in = INV;
    step();
    step();

    // Asynchronous reset asserted mid-cycle takes effect without a clock edge.
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset", 64'h0, INV, 16'h0000);
    addr = 16'h0009; wdata = 64'hFFFF_0000_FFFF_0000; mesi_state_in = MOD; we = 1'b1;
    step();
    chk("reset_overrides_we", 64'h0, INV, 16'h0000);
    we = 1'b0;
    #2;
    reset = 1'b1;
    #1;

    for (int i = 0; i < 64; i++) begin
      rd(16'(i));
      chk($sformatf("sweep_%0d", i), 64'h0, INV, 16'h0000);
    end

    wr(16'h0005, 64'hDEADBEEF_CAFEF00D, EXC);
    rd(16'h0005);
    chk("line5_read", 64'hDEADBEEF_CAFEF00D, EXC, 16'h0005);
    // Outputs hold between edges even when addr changes.
    addr = 16'h0004;
    #3;
    chk("line5_hold", 64'hDEADBEEF_CAFEF00D, EXC, 16'h0005);
    rd(16'h0004);
    chk("line4_inv", 64'h0, INV, 16'h0000);
    rd(16'h0006);
    chk("line6_inv", 64'h0, INV, 16'h0000);

    wr(16'h0007, 64'h1111, MOD);
    chk("write_first_7", 64'h1111, MOD, 16'h0007);
    rd(16'h0007);
    chk("line7_read", 64'h1111, MOD, 16'h0007);

    wr(16'hAB3F, 64'h5555, SHR);
    rd(16'h003F);
    chk("line63_tag", 64'h5555, SHR, 16'hAB3F);
    wr(16'h003F, 64'h2222, INV);
    rd(16'h003F);
    chk("line63_overwrite", 64'h2222, INV, 16'h003F);

    wr(16'h0040, 64'h3333, MOD);
    chk("oor_write_read", 64'h0, INV, 16'h0000);
    rd(16'h0040);
    chk("oor_read", 64'h0, INV, 16'h0000);
    rd(16'h0000);
    chk("line0_unchanged", 64'h0, INV, 16'h0000);
    wr(16'h00C5, 64'h4444, MOD);
    rd(16'h0005);
    chk("line5_no_alias", 64'hDEADBEEF_CAFEF00D, EXC, 16'h0005);

    for (int i = 0; i < 4; i++) begin
      wr(16'(i), 64'h10 + 64'(i), SHR);
    end
    rd(16'h0002);
    chk("fill_line2", 64'h12, SHR, 16'h0002);

    // Reset pulse lands inside a write cycle; the write must not survive.
    addr = 16'h0001; wdata = 64'h9999; mesi_state_in = MOD; we = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    chk("midop_reset_out", 64'h0, INV, 16'h0000);
    #1;
    we = 1'b0;
    #1;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rd(16'(i));
      chk($sformatf("midop_line%0d", i), 64'h0, INV, 16'h0000);
    end
    rd(16'h0005);
    chk("midop_line5", 64'h0, INV, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
